// File: rtl/flex_stp_deser_if.sv
// Lane-input / word-output bundle for the flexible deserializer.
// Driver side is master; the deserializer is slave.
interface flex_stp_deser_if #(
  parameter int NUM_BITS = 8,
  parameter int LANES    = 1
);
  localparam int CW = $clog2(NUM_BITS / LANES) + 1;

  logic                shift_enable;
  logic [LANES-1:0]    serial_in;
  logic                clear;
  logic                word_ack;
  logic [NUM_BITS-1:0] parallel_out;
  logic [NUM_BITS-1:0] word_out;
  logic                word_valid;
  logic                overrun;
  logic [CW-1:0]       shift_count;

  modport master (
    output shift_enable, serial_in, clear, word_ack,
    input  parallel_out, word_out, word_valid,
    input  overrun, shift_count
  );

  modport slave (
    input  shift_enable, serial_in, clear, word_ack,
    output parallel_out, word_out, word_valid,
    output overrun, shift_count
  );
endinterface

// File: rtl/flex_stp_deser.sv
// Multi-lane serial-to-parallel shift register with word capture,
// valid/ack handoff and sticky overrun.
module flex_stp_deser #(
  parameter int NUM_BITS   = 8,
  parameter int LANES      = 1,
  parameter bit SHIFT_MSB  = 1'b1,
  parameter bit RESET_ONES = 1'b1
) (
  input logic clk,
  input logic n_rst,
  flex_stp_deser_if.slave bus
);
  localparam int WORDS = NUM_BITS / LANES;
  localparam int CW    = $clog2(WORDS) + 1;
  localparam logic [NUM_BITS-1:0] FILL =
    RESET_ONES ? '1 : '0;

  if ((LANES < 1) || (LANES > NUM_BITS) ||
      (NUM_BITS < 2) || (NUM_BITS % LANES != 0))
  begin : g_bad_param
    $error("flex_stp_deser: bad NUM_BITS/LANES");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [NUM_BITS-1:0] word_q, word_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovr_q, ovr_d;
  logic [NUM_BITS-1:0] sr_shift;
  logic                last;
  logic                complete;

  if (LANES == NUM_BITS) begin : g_whole
    assign sr_shift = bus.serial_in;
  end else if (SHIFT_MSB) begin : g_msb
    assign sr_shift =
      {sr_q[NUM_BITS-LANES-1:0], bus.serial_in};
  end else begin : g_lsb
    assign sr_shift =
      {bus.serial_in, sr_q[NUM_BITS-1:LANES]};
  end

  assign last     = (cnt_q == CW'(WORDS - 1));
  assign complete = bus.shift_enable && last;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= EMPTY;
      sr_q    <= FILL;
      word_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    if (bus.clear) begin
      state_d = EMPTY;
      sr_d    = FILL;
      word_d  = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      if (bus.shift_enable) begin
        sr_d  = sr_shift;
        cnt_d = last ? '0 : cnt_q + 1'b1;
      end
      if (complete) begin
        word_d = sr_shift;
      end
      // a same-cycle ack frees the slot for the new word
      unique case (state_q)
        EMPTY: begin
          if (complete) state_d = FULL;
        end
        FULL: begin
          if (complete) begin
            if (!bus.word_ack) ovr_d = 1'b1;
          end else if (bus.word_ack) begin
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign bus.parallel_out = sr_q;
  assign bus.word_out     = word_q;
  assign bus.word_valid   = (state_q == FULL);
  assign bus.overrun      = ovr_q;
  assign bus.shift_count  = cnt_q;
endmodule

// File: tb/tb_flex_stp_deser.sv
// Bench for flex_stp_deser: three configurations run in lockstep
// against an arithmetic reference model.
module tb_flex_stp_deser;
  logic clk;
  logic n_rst;
  logic se, clr, ack, sin1;
  logic [3:0] sin4;

  int checks = 0;
  int errors = 0;

  int msr[3], mcnt[3], mword[3];
  int mvalid[3], movr[3];

  flex_stp_deser_if #(.NUM_BITS(8), .LANES(1)) if0 ();
  flex_stp_deser_if #(.NUM_BITS(8), .LANES(1)) if1 ();
  flex_stp_deser_if #(.NUM_BITS(8), .LANES(4)) if2 ();

  assign if0.shift_enable = se;
  assign if0.clear        = clr;
  assign if0.word_ack     = ack;
  assign if0.serial_in    = sin1;
  assign if1.shift_enable = se;
  assign if1.clear        = clr;
  assign if1.word_ack     = ack;
  assign if1.serial_in    = sin1;
  assign if2.shift_enable = se;
  assign if2.clear        = clr;
  assign if2.word_ack     = ack;
  assign if2.serial_in    = sin4;

  flex_stp_deser #(
    .NUM_BITS(8), .LANES(1), .SHIFT_MSB(1'b1), .RESET_ONES(1'b1)
  ) u0 (.clk(clk), .n_rst(n_rst), .bus(if0));

  flex_stp_deser #(
    .NUM_BITS(8), .LANES(1), .SHIFT_MSB(1'b0), .RESET_ONES(1'b1)
  ) u1 (.clk(clk), .n_rst(n_rst), .bus(if1));

  flex_stp_deser #(
    .NUM_BITS(8), .LANES(4), .SHIFT_MSB(1'b1), .RESET_ONES(1'b1)
  ) u2 (.clk(clk), .n_rst(n_rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      msr[d] = 255; mcnt[d] = 0; mword[d] = 0;
      mvalid[d] = 0; movr[d] = 0;
    end
  endtask

  // One clock edge of each configuration, from the stated rules.
  task automatic model_edge(input logic s, input logic c,
                            input logic a, input logic b1,
                            input logic [3:0] b4);
    int l, w, v;
    bit done;
    for (int d = 0; d < 3; d++) begin
      l = (d == 2) ? 4 : 1;
      w = 8 / l;
      v = (d == 2) ? int'(b4) : int'(b1);
      if (c) begin
        msr[d] = 255; mcnt[d] = 0; mword[d] = 0;
        mvalid[d] = 0; movr[d] = 0;
      end else begin
        done = s && (mcnt[d] == w - 1);
        if (mvalid[d] == 1 && a && !done) mvalid[d] = 0;
        if (s) begin
          if (d == 1)
            msr[d] = (msr[d] / (1 << l)) + v * (1 << (8 - l));
          else
            msr[d] = (msr[d] * (1 << l) + v) % 256;
          mcnt[d] = (mcnt[d] + 1) % w;
        end
        if (done) begin
          if (mvalid[d] == 1 && !a) movr[d] = 1;
          mword[d] = msr[d];
          mvalid[d] = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".u0.par"}, 32'(if0.parallel_out), 32'(msr[0]));
    chk({tag, ".u0.word"}, 32'(if0.word_out), 32'(mword[0]));
    chk({tag, ".u0.vld"}, 32'(if0.word_valid), 32'(mvalid[0]));
    chk({tag, ".u0.ovr"}, 32'(if0.overrun), 32'(movr[0]));
    chk({tag, ".u0.cnt"}, 32'(if0.shift_count), 32'(mcnt[0]));
    chk({tag, ".u1.par"}, 32'(if1.parallel_out), 32'(msr[1]));
    chk({tag, ".u1.word"}, 32'(if1.word_out), 32'(mword[1]));
    chk({tag, ".u1.vld"}, 32'(if1.word_valid), 32'(mvalid[1]));
    chk({tag, ".u1.ovr"}, 32'(if1.overrun), 32'(movr[1]));
    chk({tag, ".u1.cnt"}, 32'(if1.shift_count), 32'(mcnt[1]));
    chk({tag, ".u2.par"}, 32'(if2.parallel_out), 32'(msr[2]));
    chk({tag, ".u2.word"}, 32'(if2.word_out), 32'(mword[2]));
    chk({tag, ".u2.vld"}, 32'(if2.word_valid), 32'(mvalid[2]));
    chk({tag, ".u2.ovr"}, 32'(if2.overrun), 32'(movr[2]));
    chk({tag, ".u2.cnt"}, 32'(if2.shift_count), 32'(mcnt[2]));
  endtask

  task automatic step(input string tag, input logic s,
                      input logic c, input logic a,
                      input logic b1, input logic [3:0] b4);
    se = s; clr = c; ack = a; sin1 = b1; sin4 = b4;
    model_edge(s, c, a, b1, b4);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic shift_byte(input string tag,
                            input logic [7:0] b,
                            input logic ack_last);
    logic [3:0] r;
    for (int i = 0; i < 8; i++) begin
      r = 4'($urandom);
      step(tag, 1'b1, 1'b0, ack_last && (i == 7), b[7-i], r);
    end
  endtask

  initial begin
    logic [7:0] stream;
    n_rst = 1'b0;
    se = 0; clr = 0; ack = 0; sin1 = 0; sin4 = 0;
    model_reset();
    #7;
    check_all("rst");
    chk("rst.par", 32'(if0.parallel_out), 32'h0000_00FF);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Shift ordering: 1,1,0,1,0,0,0,0
    stream = 8'hD0;
    for (int i = 0; i < 8; i++)
      step("order", 1'b1, 1'b0, 1'b0, stream[7-i], 4'h0);
    chk("order.msb", 32'(if0.word_out), 32'h0000_00D0);
    chk("order.lsb", 32'(if1.word_out), 32'h0000_000B);
    chk("order.par", 32'(if0.parallel_out), 32'h0000_00D0);
    chk("order.cnt", 32'(if0.shift_count), 32'd0);

    // Multi-lane with gaps
    step("clr0", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    step("ml1", 1'b1, 1'b0, 1'b0, 1'b1, 4'hC);
    step("gap", 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
    chk("gap.cnt", 32'(if2.shift_count), 32'd1);
    step("gap", 1'b0, 1'b0, 1'b0, 1'b0, 4'hA);
    chk("gap.cnt2", 32'(if2.shift_count), 32'd1);
    step("ml2", 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
    chk("ml.word", 32'(if2.word_out), 32'h0000_00C3);
    chk("ml.vld", 32'(if2.word_valid), 32'd1);

    // Overrun and handshake
    step("clr1", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    shift_byte("ovA", 8'hD0, 1'b0);
    shift_byte("ovB", 8'h5A, 1'b0);
    chk("ov.word", 32'(if0.word_out), 32'h0000_005A);
    chk("ov.flag", 32'(if0.overrun), 32'd1);
    step("ack", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("ack.vld", 32'(if0.word_valid), 32'd0);
    chk("ack.ovr", 32'(if0.overrun), 32'd1);
    step("clr2", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    shift_byte("coA", 8'h3C, 1'b0);
    shift_byte("coB", 8'hE7, 1'b1);
    chk("co.vld", 32'(if0.word_valid), 32'd1);
    chk("co.ovr", 32'(if0.overrun), 32'd0);
    chk("co.word", 32'(if0.word_out), 32'h0000_00E7);

    // Clear mid-word wins over shift
    for (int i = 0; i < 3; i++)
      step("pre", 1'b1, 1'b0, 1'b0, 1'b0, 4'h6);
    step("mclr", 1'b1, 1'b1, 1'b0, 1'b0, 4'h6);
    chk("mclr.par", 32'(if0.parallel_out), 32'h0000_00FF);
    chk("mclr.cnt", 32'(if0.shift_count), 32'd0);

    // Async reset mid-cycle after a partial word
    for (int i = 0; i < 3; i++)
      step("pre2", 1'b1, 1'b0, 1'b0, 1'b1, 4'h9);
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    check_all("arst");
    #1;
    n_rst = 1'b1;
    for (int i = 0; i < 7; i++)
      step("post", 1'b1, 1'b0, 1'b0, 1'b1, 4'h1);
    chk("post.vld7", 32'(if0.word_valid), 32'd0);
    step("post8", 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
    chk("post.vld8", 32'(if0.word_valid), 32'd1);
    chk("post.word", 32'(if0.word_out), 32'h0000_00FE);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 3),
           1'($urandom),
           4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flex_stp_deser.md
Name: flex_stp_deser

Overview:
Parametrised serial-to-parallel deserializer for the receive datapath. It is the next-generation flexible STP shift register, adding:
- multi-lane shifting (LANES bits per shift)
- a word-boundary counter
- a captured output word with valid/ack handshake
- sticky overrun detection and a synchronous clear

It sits between a bit/lane sampler and the downstream word consumer (FIFO or decoder).

Parameters:
NUM_BITS, 8, shift-register and word width; must be ≥2 and an integer multiple of LANES.
LANES, 1, serial bits accepted per shift; 1 ≤ LANES ≤ NUM_BITS.
SHIFT_MSB, 1, 1 = shift toward MSB (new data enters at LSB end); 0 = shift toward LSB (new data enters at MSB end).
RESET_ONES, 1, idle/reset fill of the shift register: 1 = all ones, 0 = all zeros.

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  asynchronous active-low reset.
shift_enable  input  1  shift one LANES-wide group this cycle.
serial_in  input  LANES  incoming lane data.
clear  input  1  synchronous clear; highest priority after reset.
word_ack  input  1  consumer accepts word_out.
parallel_out  output  NUM_BITS  live shift-register contents.
word_out  output  NUM_BITS  last completed word.
word_valid  output  1  word_out holds an unconsumed word.
overrun  output  1  sticky: a completed word overwrote an unacknowledged one.
shift_count  output  clog2(NUM_BITS/LANES)+1  shifts taken in the current word, 0..NUM_BITS/LANES-1.

Behaviour:
- Reset (async, n_rst=0):
  - parallel_out = fill (all 1s if RESET_ONES else all 0s)
  - word_out = 0, word_valid = 0, overrun = 0, shift_count = 0
- Priority each edge: clear > shift_enable > hold.
- clear=1: same values as reset, applied synchronously; shift_enable and word_ack are ignored that cycle.
- Shift, SHIFT_MSB=1: sr <= {sr[NUM_BITS-LANES-1:0], serial_in}.
- Shift, SHIFT_MSB=0: sr <= {serial_in, sr[NUM_BITS-1:LANES]}.
- Shift when LANES == NUM_BITS: sr <= serial_in.
- serial_in bit order is preserved within a lane group; no reversal.
- shift_enable=0: sr and shift_count hold.
- Counter:
  - Each shift increments shift_count.
  - A shift taken with shift_count == NUM_BITS/LANES-1 is the word-completing shift; shift_count wraps to 0.
- Word capture on a completing shift, all at the same edge:
  - word_out <= the post-shift value, so word_out equals parallel_out on the following cycle.
  - word_valid <= 1.
  - Latency: word visible 1 cycle after the completing shift edge, the same edge parallel_out updates.
- Handshake as a two-state machine on word_valid:
  - EMPTY (word_valid=0): word_ack ignored; a completing shift moves to FULL.
  - FULL (word_valid=1): word_ack=1 with no completion moves to EMPTY.
  - FULL, completion with word_ack=1 in the same cycle: stay FULL with the new word; no overrun.
  - FULL, completion with word_ack=0: overwrite word_out, stay FULL, set overrun.
- overrun: cleared only by reset or clear; word_ack does not clear it.
- Mid-word reset or clear: the partial word is discarded and the next word needs a full NUM_BITS/LANES shifts.
- Shift register is not re-filled after a word completes; parallel_out keeps shifting continuously.
- Elaboration error if NUM_BITS % LANES != 0 or LANES > NUM_BITS.

Test Plan:
- Reset, defaults (NUM_BITS=8, LANES=1, SHIFT_MSB=1): n_rst low → parallel_out=8'hFF, word_out=0, word_valid=0, overrun=0, shift_count=0.
- Shift ordering, defaults: shift 1,1,0,1,0,0,0,0 on consecutive cycles → after the 8th edge parallel_out=word_out=8'hD0, word_valid=1, shift_count=0. Same stream with SHIFT_MSB=0 → 8'h0B.
- Multi-lane, LANES=4: serial_in=4'hC then 4'h3 → word_out=8'hC3, word_valid=1 after 2 shifts. Insert shift_enable=0 gaps between the two shifts → identical result, shift_count holds at 1 during the gaps.
- Overrun and handshake:
  - Complete 8'hD0 with no ack, then complete 8'h5A → word_out=8'h5A, word_valid=1, overrun=1.
  - Then word_ack → word_valid=0, overrun stays 1.
  - Completion coincident with ack on another word → word_valid stays 1, overrun unchanged.
- Clear and reset mid-word:
  - After 3 shifts, assert clear with shift_enable=1 → parallel_out=8'hFF, shift_count=0, overrun=0; the shift is ignored.
  - Repeat with an async n_rst pulse mid-cycle → same values immediately. The next word completes only after 8 further shifts.
